// File: rtl/hazard_pkg.sv
// Shared encodings, FSM state type and defaults for the multi-lane hazard unit.
package hazard_pkg;

    localparam int unsigned REG_AW_DEF = 5;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic {
        IDLE    = 1'b0,
        MC_WAIT = 1'b1
    } mc_state_e;

    // Width of a lane index; a single-lane build still needs one bit.
    function automatic int unsigned lane_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hazard_unit_multi_pe_if.sv
// Pipeline <-> hazard unit signal bundle; master is the pipeline, slave the hazard unit.
interface hazard_unit_multi_pe_if
    import hazard_pkg::*;
#(
    parameter int unsigned NUM_PE = 2,
    parameter int unsigned REG_AW = REG_AW_DEF
);
    localparam int unsigned LW = lane_w(NUM_PE);

    logic [NUM_PE-1:0]        RegWriteM, RegWriteW, RegWriteE;
    logic [NUM_PE-1:0]        LoadE, McStartE, McUseD;
    logic [NUM_PE*REG_AW-1:0] RD_M, RD_W, RD_E;
    logic [NUM_PE*REG_AW-1:0] Rs1_E, Rs2_E, Rs1_D, Rs2_D;
    logic [2*NUM_PE-1:0]      ForwardAE, ForwardBE;
    logic [NUM_PE*LW-1:0]     FwdLaneA, FwdLaneB;
    logic                     StallF, StallD, FlushE;
    logic                     McBusy, McDone;

    modport master (
        output RegWriteM, RegWriteW, RegWriteE, LoadE, McStartE, McUseD,
        output RD_M, RD_W, RD_E, Rs1_E, Rs2_E, Rs1_D, Rs2_D,
        input  ForwardAE, ForwardBE, FwdLaneA, FwdLaneB,
        input  StallF, StallD, FlushE, McBusy, McDone
    );

    modport slave (
        input  RegWriteM, RegWriteW, RegWriteE, LoadE, McStartE, McUseD,
        input  RD_M, RD_W, RD_E, Rs1_E, Rs2_E, Rs1_D, Rs2_D,
        output ForwardAE, ForwardBE, FwdLaneA, FwdLaneB,
        output StallF, StallD, FlushE, McBusy, McDone
    );

endinterface

// File: rtl/fwd_select.sv
// Priority search for one E-stage source: M beats W, younger (higher) lane beats older.
module fwd_select
    import hazard_pkg::*;
#(
    parameter int unsigned NUM_PE = 2,
    parameter int unsigned REG_AW = REG_AW_DEF,
    parameter int unsigned LW     = 1
) (
    input  logic [REG_AW-1:0]        src,
    input  logic [NUM_PE-1:0]        wen_m,
    input  logic [NUM_PE*REG_AW-1:0] rd_m,
    input  logic [NUM_PE-1:0]        wen_w,
    input  logic [NUM_PE*REG_AW-1:0] rd_w,
    output logic [1:0]               fwd_c,
    output logic [LW-1:0]            lane_c
);

    logic          m_hit_c, w_hit_c;
    logic [LW-1:0] m_lane_c, w_lane_c;

    // Ascending scan so the last (highest) qualifying lane is the one kept.
    always_comb begin
        m_hit_c  = 1'b0;
        w_hit_c  = 1'b0;
        m_lane_c = '0;
        w_lane_c = '0;
        for (int unsigned i = 0; i < NUM_PE; i++) begin
            if (wen_m[i] && (rd_m[i*REG_AW +: REG_AW] != '0) && (rd_m[i*REG_AW +: REG_AW] == src)) begin
                m_hit_c  = 1'b1;
                m_lane_c = LW'(i);
            end
            if (wen_w[i] && (rd_w[i*REG_AW +: REG_AW] != '0) && (rd_w[i*REG_AW +: REG_AW] == src)) begin
                w_hit_c  = 1'b1;
                w_lane_c = LW'(i);
            end
        end
    end

    always_comb begin
        fwd_c  = FWD_RF;
        lane_c = '0;
        if (m_hit_c) begin
            fwd_c  = FWD_M;
            lane_c = m_lane_c;
        end else if (w_hit_c) begin
            fwd_c  = FWD_W;
            lane_c = w_lane_c;
        end
    end

endmodule

// File: rtl/hazard_unit_multi_pe.sv
// Multi-lane forwarding, load-use stall and multi-cycle-unit scoreboard.
// The scoreboard/FSM is built only when HAZARD_MC_SCOREBOARD_EN is defined.
module hazard_unit_multi_pe
    import hazard_pkg::*;
#(
    parameter int unsigned NUM_PE = 2,
    parameter int unsigned REG_AW = REG_AW_DEF,
    parameter int unsigned MC_LAT = 4
) (
    input logic                   clk,
    input logic                   rst,
    hazard_unit_multi_pe_if.slave hz
);

    localparam int unsigned LW = lane_w(NUM_PE);

    logic load_use_c;
    logic mc_haz_c;
    logic flush_c;

    for (genvar i = 0; i < NUM_PE; i++) begin : g_lane
        logic [1:0]    fa_c, fb_c;
        logic [LW-1:0] la_c, lb_c;

        fwd_select #(.NUM_PE(NUM_PE), .REG_AW(REG_AW), .LW(LW)) u_fwd_a (
            .src    (hz.Rs1_E[i*REG_AW +: REG_AW]),
            .wen_m  (hz.RegWriteM),
            .rd_m   (hz.RD_M),
            .wen_w  (hz.RegWriteW),
            .rd_w   (hz.RD_W),
            .fwd_c  (fa_c),
            .lane_c (la_c)
        );

        fwd_select #(.NUM_PE(NUM_PE), .REG_AW(REG_AW), .LW(LW)) u_fwd_b (
            .src    (hz.Rs2_E[i*REG_AW +: REG_AW]),
            .wen_m  (hz.RegWriteM),
            .rd_m   (hz.RD_M),
            .wen_w  (hz.RegWriteW),
            .rd_w   (hz.RD_W),
            .fwd_c  (fb_c),
            .lane_c (lb_c)
        );

        assign hz.ForwardAE[2*i +: 2]  = rst ? FWD_RF : fa_c;
        assign hz.ForwardBE[2*i +: 2]  = rst ? FWD_RF : fb_c;
        assign hz.FwdLaneA[i*LW +: LW] = rst ? '0 : la_c;
        assign hz.FwdLaneB[i*LW +: LW] = rst ? '0 : lb_c;
    end

    // Any qualifying E-stage load whose destination is read by any D-stage lane.
    always_comb begin
        load_use_c = 1'b0;
        for (int unsigned j = 0; j < NUM_PE; j++) begin
            if (hz.LoadE[j] && hz.RegWriteE[j] && (hz.RD_E[j*REG_AW +: REG_AW] != '0)) begin
                for (int unsigned k = 0; k < NUM_PE; k++) begin
                    if ((hz.RD_E[j*REG_AW +: REG_AW] == hz.Rs1_D[k*REG_AW +: REG_AW]) ||
                        (hz.RD_E[j*REG_AW +: REG_AW] == hz.Rs2_D[k*REG_AW +: REG_AW]))
                        load_use_c = 1'b1;
                end
            end
        end
    end

`ifdef HAZARD_MC_SCOREBOARD_EN
    localparam int unsigned CW = $clog2(MC_LAT);

    mc_state_e   state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [REG_AW-1:0] mc_rd_q, mc_rd_d;
    logic              start_c;
    logic [REG_AW-1:0] start_rd_c;
    logic              rd_match_c;

    // Issue detection; the youngest issuing lane supplies the tracked destination.
    always_comb begin
        start_c    = 1'b0;
        start_rd_c = '0;
        rd_match_c = 1'b0;
        for (int unsigned i = 0; i < NUM_PE; i++) begin
            if (hz.McStartE[i]) begin
                start_c    = 1'b1;
                start_rd_c = hz.RD_E[i*REG_AW +: REG_AW];
            end
            if ((hz.Rs1_D[i*REG_AW +: REG_AW] == mc_rd_q) || (hz.Rs2_D[i*REG_AW +: REG_AW] == mc_rd_q))
                rd_match_c = 1'b1;
        end
    end

    // Stall released on the final count so the consumer meets the W-stage forward.
    assign mc_haz_c = (state_q == MC_WAIT) && (cnt_q != '0) &&
                      (((mc_rd_q != '0) && rd_match_c) || (|hz.McUseD));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mc_rd_d = mc_rd_q;
        case (state_q)
            IDLE: begin
                if (start_c && !flush_c) begin
                    state_d = MC_WAIT;
                    cnt_d   = CW'(MC_LAT - 1);
                    mc_rd_d = start_rd_c;
                end
            end
            MC_WAIT: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - CW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mc_rd_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mc_rd_q <= mc_rd_d;
        end
    end

    assign hz.McBusy = !rst && (state_q == MC_WAIT);
    assign hz.McDone = !rst && (state_q == MC_WAIT) && (cnt_q == '0);
`else
    localparam int unsigned UNUSED_MC_LAT = MC_LAT;
    logic unused_mc_c;

    assign unused_mc_c = ^{clk, hz.McStartE, hz.McUseD, UNUSED_MC_LAT[0]};
    assign mc_haz_c    = 1'b0;
    assign hz.McBusy   = 1'b0;
    assign hz.McDone   = 1'b0;
`endif

    assign flush_c   = load_use_c | mc_haz_c;
    assign hz.StallF = !rst && flush_c;
    assign hz.StallD = !rst && flush_c;
    assign hz.FlushE = !rst && flush_c;

endmodule

// File: tb/tb_hazard_unit_multi_pe.sv
// Directed bench for hazard_unit_multi_pe (NUM_PE=2, REG_AW=5, MC_LAT=4);
// MC scoreboard checks follow HAZARD_MC_SCOREBOARD_EN.
module tb_hazard_unit_multi_pe;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    hazard_unit_multi_pe_if #(.NUM_PE(2), .REG_AW(5)) hz ();

    hazard_unit_multi_pe #(.NUM_PE(2), .REG_AW(5), .MC_LAT(4)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_stall(input string tag, input logic exp);
        chk({tag, "_stallf"}, 32'(hz.StallF), 32'(exp));
        chk({tag, "_stalld"}, 32'(hz.StallD), 32'(exp));
        chk({tag, "_flushe"}, 32'(hz.FlushE), 32'(exp));
    endtask

    task automatic clr_in();
        hz.RegWriteM = '0; hz.RegWriteW = '0; hz.RegWriteE = '0;
        hz.LoadE     = '0; hz.McStartE  = '0; hz.McUseD    = '0;
        hz.RD_M  = '0; hz.RD_W  = '0; hz.RD_E  = '0;
        hz.Rs1_E = '0; hz.Rs2_E = '0; hz.Rs1_D = '0; hz.Rs2_D = '0;
    endtask

    // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        clr_in();
        next_cycle();
        next_cycle();

        // Reset gates outputs even with forwarding and load-use inputs present.
        hz.RegWriteM = 2'b01; hz.RD_M = {5'd0, 5'd5}; hz.Rs1_E = {5'd0, 5'd5};
        hz.LoadE = 2'b01; hz.RegWriteE = 2'b01; hz.RD_E = {5'd0, 5'd4}; hz.Rs1_D = {5'd0, 5'd4};
        hz.McStartE = 2'b01;
        #1;
        chk("rst_fwda", 32'(hz.ForwardAE), 32'h0);
        chk("rst_lanea", 32'(hz.FwdLaneA), 32'h0);
        chk_stall("rst", 1'b0);
        chk("rst_busy", 32'(hz.McBusy), 32'h0);
        chk("rst_done", 32'(hz.McDone), 32'h0);

        next_cycle();
        rst = 1'b0;
        clr_in();
        #1;
        chk("idle_fwda", 32'(hz.ForwardAE), 32'h0);
        chk("idle_busy", 32'(hz.McBusy), 32'h0);
        chk_stall("idle", 1'b0);

        // Both M lanes write x5: younger lane1 wins for lane0 Rs1_E.
        next_cycle();
        hz.RegWriteM = 2'b11; hz.RD_M = {5'd5, 5'd5}; hz.Rs1_E = {5'd0, 5'd5};
        #1;
        chk("m_both_fwda", 32'(hz.ForwardAE), 32'b0010);
        chk("m_both_lanea", 32'(hz.FwdLaneA), 32'b01);
        chk("m_both_fwdb", 32'(hz.ForwardBE), 32'h0);

        // M lane0 beats W lane1 on x7 for lane1 Rs2_E.
        next_cycle();
        clr_in();
        hz.RegWriteW = 2'b10; hz.RD_W = {5'd7, 5'd0};
        hz.RegWriteM = 2'b01; hz.RD_M = {5'd0, 5'd7};
        hz.Rs2_E = {5'd7, 5'd0};
        #1;
        chk("m_over_w_fwdb", 32'(hz.ForwardBE), 32'b1000);
        chk("m_over_w_laneb", 32'(hz.FwdLaneB), 32'b00);
        chk("m_over_w_fwda", 32'(hz.ForwardAE), 32'h0);

        // Only the W writer remains: 01 from lane1.
        next_cycle();
        hz.RegWriteM = 2'b00;
        #1;
        chk("w_only_fwdb", 32'(hz.ForwardBE), 32'b0100);
        chk("w_only_laneb", 32'(hz.FwdLaneB), 32'b10);

        // Writers to x0 never forward, even to a source of x0.
        next_cycle();
        clr_in();
        hz.RegWriteM = 2'b11; hz.RD_M = '0; hz.RegWriteW = 2'b11; hz.RD_W = '0;
        #1;
        chk("x0_fwda", 32'(hz.ForwardAE), 32'h0);
        chk("x0_fwdb", 32'(hz.ForwardBE), 32'h0);

        // Disabled M writer ignored; W lanes both write x3, lane1 wins.
        next_cycle();
        clr_in();
        hz.RegWriteM = 2'b00; hz.RD_M = {5'd3, 5'd3};
        hz.RegWriteW = 2'b11; hz.RD_W = {5'd3, 5'd3};
        hz.Rs1_E = {5'd3, 5'd3}; hz.Rs2_E = {5'd3, 5'd9};
        #1;
        chk("w_both_fwda", 32'(hz.ForwardAE), 32'b0101);
        chk("w_both_lanea", 32'(hz.FwdLaneA), 32'b11);
        chk("w_both_fwdb", 32'(hz.ForwardBE), 32'b0100);
        chk("w_both_laneb", 32'(hz.FwdLaneB), 32'b10);

        // Load-use: lane1 loads x3, lane0 Rs2_D reads x3.
        next_cycle();
        clr_in();
        hz.LoadE = 2'b10; hz.RegWriteE = 2'b10; hz.RD_E = {5'd3, 5'd0}; hz.Rs2_D = {5'd0, 5'd3};
        #1;
        chk_stall("lu_hit", 1'b1);
        next_cycle();
        hz.LoadE = '0; hz.RegWriteE = '0; hz.RD_E = '0;
        #1;
        chk_stall("lu_after", 1'b0);

        // Non-qualifying loads: no writeback, or destination x0.
        next_cycle();
        hz.LoadE = 2'b01; hz.RegWriteE = 2'b00; hz.RD_E = {5'd0, 5'd3};
        #1;
        chk("lu_nowe", 32'(hz.StallF), 32'h0);
        next_cycle();
        hz.RegWriteE = 2'b01; hz.RD_E = '0; hz.Rs1_D = '0; hz.Rs2_D = '0;
        #1;
        chk("lu_x0", 32'(hz.StallF), 32'h0);

`ifdef HAZARD_MC_SCOREBOARD_EN
        // MC issue to x9, dependent in D: 3 stall cycles, McDone on the 4th.
        next_cycle();
        clr_in();
        hz.McStartE = 2'b01; hz.RD_E = {5'd0, 5'd9};
        #1;
        chk("mc_issue_busy", 32'(hz.McBusy), 32'h0);
        chk_stall("mc_issue", 1'b0);
        next_cycle();
        clr_in();
        hz.Rs1_D = {5'd0, 5'd9};
        for (int c = 0; c < 3; c++) begin
            #1;
            chk_stall("mc_wait", 1'b1);
            chk("mc_wait_busy", 32'(hz.McBusy), 32'h1);
            chk("mc_wait_done", 32'(hz.McDone), 32'h0);
            next_cycle();
        end
        #1;
        chk("mc_final_done", 32'(hz.McDone), 32'h1);
        chk("mc_final_busy", 32'(hz.McBusy), 32'h1);
        chk_stall("mc_final", 1'b0);
        next_cycle();
        #1;
        chk("mc_post_busy", 32'(hz.McBusy), 32'h0);
        chk("mc_post_done", 32'(hz.McDone), 32'h0);
        chk_stall("mc_post", 1'b0);

        // Two lanes issue: lane1's x12 is tracked, x9 is not; McUseD stalls regardless.
        next_cycle();
        clr_in();
        hz.McStartE = 2'b11; hz.RD_E = {5'd12, 5'd9};
        next_cycle();
        clr_in();
        hz.Rs1_D = {5'd0, 5'd9};
        #1;
        chk("mc_hi_old", 32'(hz.StallF), 32'h0);
        next_cycle();
        hz.Rs1_D = {5'd12, 5'd0};
        #1;
        chk("mc_hi_young", 32'(hz.StallF), 32'h1);
        next_cycle();
        clr_in();
        hz.McUseD = 2'b10;
        #1;
        chk("mc_use", 32'(hz.StallF), 32'h1);
        next_cycle();
        #1;
        chk("mc_use_done", 32'(hz.McDone), 32'h1);
        chk("mc_use_final", 32'(hz.StallF), 32'h0);

        // Issue coinciding with a load-use flush is dropped.
        next_cycle();
        clr_in();
        hz.McStartE = 2'b01; hz.RD_E = {5'd4, 5'd9};
        hz.LoadE = 2'b10; hz.RegWriteE = 2'b10; hz.Rs1_D = {5'd4, 5'd0};
        #1;
        chk("mc_flush_stall", 32'(hz.StallF), 32'h1);
        next_cycle();
        clr_in();
        #1;
        chk("mc_flush_busy", 32'(hz.McBusy), 32'h0);

        // Reset in the second MC_WAIT cycle aborts the op without McDone.
        next_cycle();
        hz.McStartE = 2'b01; hz.RD_E = {5'd0, 5'd9};
        next_cycle();
        clr_in();
        hz.Rs1_D = {5'd0, 5'd9};
        #1;
        chk("mc_rst_w1", 32'(hz.McBusy), 32'h1);
        next_cycle();
        rst = 1'b1;
        #1;
        chk("mc_rst_busy", 32'(hz.McBusy), 32'h0);
        chk_stall("mc_rst", 1'b0);
        next_cycle();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("mc_rstpost_busy", 32'(hz.McBusy), 32'h0);
            chk("mc_rstpost_done", 32'(hz.McDone), 32'h0);
            chk("mc_rstpost_stall", 32'(hz.StallF), 32'h0);
            next_cycle();
        end
`else
        // Scoreboard absent: MC inputs have no effect.
        next_cycle();
        clr_in();
        hz.McStartE = 2'b01; hz.RD_E = {5'd0, 5'd9};
        #1;
        chk("nomc_issue_stall", 32'(hz.StallF), 32'h0);
        next_cycle();
        clr_in();
        hz.Rs1_D = {5'd0, 5'd9}; hz.McUseD = 2'b11;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("nomc_busy", 32'(hz.McBusy), 32'h0);
            chk("nomc_done", 32'(hz.McDone), 32'h0);
            chk_stall("nomc", 1'b0);
            next_cycle();
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
